// File: rtl/urv_iram_loader.sv
// urv_iram_loader: host byte-stream to IRAM port B bridge.
// Decodes WRITE/READ/HOLD/RUN commands from a byte link, issues word
// accesses on the IRAM port and streams read data back to the host.
// Optional: define URV_LOADER_AUTOINC_EN to enable the 0x03 BURST opcode
// (auto-incrementing multi-word write). Without it 0x03 is an unknown opcode.
//
// Handshake: a byte moves on rx when rx_valid_i && rx_ready_o and on tx when
// tx_valid_o && tx_ready_i, both sampled at the rising clock edge; a source
// holds its data stable until the transfer happens.
module urv_iram_loader #(
    parameter int g_size              = 65536,
    parameter bit g_hold_cpu_at_reset = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        enb_o,
    output logic        web_o,
    output logic [31:0] ab_o,
    output logic [3:0]  bweb_o,
    output logic [31:0] db_o,
    input  logic [31:0] qb_i,
    output logic        cpu_rst_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WR,
        S_RDREQ,
        S_RDWAIT,
        S_TX
`ifdef URV_LOADER_AUTOINC_EN
        , S_CNT
`endif
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_BURST
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        err_q, err_d;
`ifdef URV_LOADER_AUTOINC_EN
    logic [15:0] count_q, count_d;
`endif

    logic [31:0] addr_mod;
    logic        rx_fire;

    // Wrap the address into the IRAM and drop the byte-lane bits.
    assign addr_mod = addr_q % 32'(g_size);

    assign ab_o       = addr_mod & 32'hFFFF_FFFC;
    assign db_o       = data_q;
    assign bweb_o     = 4'hf;
    assign tx_data_o  = data_q[31:24];
    assign tx_valid_o = (state_q == S_TX);
    assign enb_o      = (state_q == S_WR) || (state_q == S_RDREQ);
    assign web_o      = (state_q == S_WR);
    assign cpu_rst_o  = cpu_rst_q;
    assign err_o      = err_q;
    assign rx_fire    = rx_valid_i && rx_ready_o;

    // State, counters and shift registers; everything returns to idle on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= OP_WRITE;
            cnt_q     <= 2'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            cpu_rst_q <= g_hold_cpu_at_reset;
            err_q     <= 1'b0;
`ifdef URV_LOADER_AUTOINC_EN
            count_q   <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
`ifdef URV_LOADER_AUTOINC_EN
            count_q   <= count_d;
`endif
        end
    end

    // Command decode, byte shifting and IRAM/tx sequencing.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = 1'b0;
`ifdef URV_LOADER_AUTOINC_EN
        count_d    = count_q;
`endif
        rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA)
`ifdef URV_LOADER_AUTOINC_EN
                     || (state_q == S_CNT)
`endif
                     ;

        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    case (rx_data_i)
                        8'h01: begin op_d = OP_WRITE; state_d = S_ADDR; end
                        8'h02: begin op_d = OP_READ;  state_d = S_ADDR; end
`ifdef URV_LOADER_AUTOINC_EN
                        8'h03: begin op_d = OP_BURST; state_d = S_ADDR; end
`endif
                        8'h10: cpu_rst_d = 1'b1;
                        8'h11: cpu_rst_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d = {addr_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (op_q == OP_READ)
                            state_d = S_RDREQ;
`ifdef URV_LOADER_AUTOINC_EN
                        else if (op_q == OP_BURST)
                            state_d = S_CNT;
`endif
                        else
                            state_d = S_DATA;
                    end
                end
            end
`ifdef URV_LOADER_AUTOINC_EN
            S_CNT: begin
                if (rx_fire) begin
                    count_d = {count_q[7:0], rx_data_i};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ({count_q[7:0], rx_data_i} == 16'd0) ? S_IDLE : S_DATA;
                    end
                end
            end
`endif
            S_DATA: begin
                if (rx_fire) begin
                    data_d = {data_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_WR;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
`ifdef URV_LOADER_AUTOINC_EN
                if (op_q == OP_BURST) begin
                    count_d = count_q - 16'd1;
                    addr_d  = (ab_o + 32'd4) % 32'(g_size);
                    if (count_q != 16'd1)
                        state_d = S_DATA;
                end
`endif
            end
            S_RDREQ: state_d = S_RDWAIT;
            S_RDWAIT: begin
                data_d  = qb_i;
                cnt_d   = 2'd0;
                state_d = S_TX;
            end
            S_TX: begin
                if (tx_ready_i) begin
                    data_d = {data_q[23:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
